// File: rtl/mux_rr_reg_if.sv
// Handshake bundle between N producers, the mux_rr_reg merge point and one consumer.
//   d/v/rdy         : per-channel data, valid and ready (producer side)
//   mode/s          : selection control (0 = fixed channel s, 1 = round-robin)
//   y/y_valid/y_sel : registered output word, its valid flag and source channel
//   y_ready         : downstream ready
// master = the environment driving producers/consumer, slave = the merge block.
interface mux_rr_reg_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] d;
  logic [N-1:0]   v;
  logic [N-1:0]   rdy;
  logic           mode;
  logic [SW-1:0]  s;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;
  logic [SW-1:0]  y_sel;

  modport master (
    output d, v, mode, s, y_ready,
    input  rdy, y, y_valid, y_sel
  );

  modport slave (
    input  d, v, mode, s, y_ready,
    output rdy, y, y_valid, y_sel
  );
endinterface

// File: rtl/mux_rr_reg.sv
// N-channel merge with a one-entry registered output buffer.
// Fixed mode forwards channel s; round-robin mode grants the first valid
// channel at or after the rotating pointer.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_reg_if slave modport (d, v, rdy, mode, s, y, y_valid, y_ready, y_sel)
module mux_rr_reg #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_reg_if.slave    bus
);

  logic [W-1:0]  r_y;
  logic          r_valid;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_ptr;

  logic          w_can_accept;
  logic          w_has_grant;
  logic [SW-1:0] w_grant;
  logic [N-1:0]  w_rdy;
  logic          w_xfer;

  // Gated with rst_n so that no ready is offered while reset is held.
  assign w_can_accept = rst_n & (~r_valid | bus.y_ready);

  always_comb begin
    w_has_grant = 1'b0;
    w_grant     = '0;
    if (!bus.mode) begin
      if (int'(bus.s) < N) begin
        w_has_grant = 1'b1;
        w_grant     = bus.s;
      end
    end else begin
      // Scan from the far end back toward ptr so the last hit is the
      // first valid channel in rotation order.
      for (int k = N - 1; k >= 0; k--) begin
        if (bus.v[(int'(r_ptr) + k) % N]) begin
          w_has_grant = 1'b1;
          w_grant     = SW'((int'(r_ptr) + k) % N);
        end
      end
    end
  end

  always_comb begin
    w_rdy = '0;
    if (w_can_accept && w_has_grant) begin
      w_rdy[w_grant] = 1'b1;
    end
  end

  assign w_xfer = w_can_accept & w_has_grant & bus.v[w_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_y     <= bus.d[int'(w_grant)*W +: W];
      r_sel   <= w_grant;
      r_valid <= 1'b1;
      if (bus.mode) begin
        r_ptr <= (int'(w_grant) == N - 1) ? '0 : w_grant + 1'b1;
      end
    end else if (bus.y_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.rdy     = w_rdy;
  assign bus.y       = r_y;
  assign bus.y_valid = r_valid;
  assign bus.y_sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_reg.sv
module tb_mux_rr_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_rr_reg_if #(.N(4), .W(8)) bus4 ();
  mux_rr_reg_if #(.N(3), .W(8)) bus3 ();

  mux_rr_reg #(.N(4), .W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  mux_rr_reg #(.N(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         valid;
    logic [7:0] y;
    int         sel;
    int         ptr;
  } mst_t;

  mst_t m4, m3;
  logic [3:0] last_rdy4, last_rdy3;

  typedef struct {
    logic       mode;
    logic [1:0] s;
    logic [3:0] v;
    logic       yr;
    logic [3:0] e_rdy;
    logic       e_valid;
    logic [7:0] e_y;
    logic [1:0] e_sel;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: grant taken from the rules directly (fixed index, or first
  // valid channel in the rotation ptr, ptr+1, ... mod n).
  function automatic void model_step(input int n, input bit rstn, input bit mode, input int s,
                                     input logic [3:0] v, input logic [31:0] d, input bit yr,
                                     input mst_t cur, output logic [3:0] rdy, output mst_t nxt);
    bit has;
    int g;
    bit can;
    has = 0;
    g = 0;
    nxt = cur;
    rdy = '0;
    if (!rstn) begin
      nxt = '{valid: 0, y: 8'h00, sel: 0, ptr: 0};
      return;
    end
    if (mode == 0) begin
      if (s < n) begin has = 1; g = s; end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (!has && v[(cur.ptr + k) % n]) begin has = 1; g = (cur.ptr + k) % n; end
      end
    end
    can = !cur.valid || yr;
    if (has && can) rdy[g] = 1'b1;
    if (has && can && v[g]) begin
      nxt.valid = 1;
      nxt.y = d[g*8 +: 8];
      nxt.sel = g;
      if (mode) nxt.ptr = (g + 1) % n;
    end else if (yr) begin
      nxt.valid = 0;
    end
  endfunction

  task automatic cycle();
    mst_t n4, n3;
    logic [3:0] e4, e3;
    #1;
    model_step(4, rst_n, bus4.mode, int'(bus4.s), bus4.v, bus4.d, bus4.y_ready, m4, e4, n4);
    model_step(3, rst_n, bus3.mode, int'(bus3.s), {1'b0, bus3.v}, {8'h00, bus3.d}, bus3.y_ready, m3, e3, n3);
    last_rdy4 = bus4.rdy;
    last_rdy3 = {1'b0, bus3.rdy};
    chk("model_rdy4", 32'(last_rdy4), 32'(e4));
    chk("model_rdy3", 32'(last_rdy3), 32'(e3));
    @(posedge clk);
    m4 = n4;
    m3 = n3;
    #1;
    chk("model_valid4", 32'(bus4.y_valid), 32'(m4.valid));
    chk("model_valid3", 32'(bus3.y_valid), 32'(m3.valid));
    chk("model_y4", 32'(bus4.y), 32'(m4.y));
    chk("model_y3", 32'(bus3.y), 32'(m3.y));
    chk("model_sel4", 32'(bus4.y_sel), 32'(m4.sel));
    chk("model_sel3", 32'(bus3.y_sel), 32'(m3.sel));
  endtask

  task automatic chk4(input string name, input logic [3:0] rdy, input logic valid,
                      input logic [7:0] y, input logic [1:0] sel);
    chk({name, "_rdy"}, 32'(last_rdy4), 32'(rdy));
    chk({name, "_valid"}, 32'(bus4.y_valid), 32'(valid));
    chk({name, "_y"}, 32'(bus4.y), 32'(y));
    chk({name, "_sel"}, 32'(bus4.y_sel), 32'(sel));
  endtask

  initial begin
    m4 = '{valid: 0, y: 8'h00, sel: 0, ptr: 0};
    m3 = m4;
    bus4.d = 32'h44332211; bus4.v = 4'b1111; bus4.mode = 1'b0; bus4.s = 2'd2; bus4.y_ready = 1'b1;
    bus3.d = 24'h332211;   bus3.v = 3'b000;  bus3.mode = 1'b0; bus3.s = 2'd3; bus3.y_ready = 1'b1;

    // Reset held for 3 cycles with traffic offered: nothing may be granted.
    rst_n = 1'b0;
    repeat (3) begin
      cycle();
      chk4("in_reset", 4'b0000, 1'b0, 8'h00, 2'd0);
    end
    rst_n = 1'b1;
    bus4.mode = 1'b1; bus4.v = 4'b0000;
    repeat (2) begin
      cycle();
      chk4("idle", 4'b0000, 1'b0, 8'h00, 2'd0);
    end

    // Fixed mode, then round-robin with wrap-around, then v=1001 alternation, then drain.
    tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[2]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[9]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[10] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
    tbl[14] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd0};
    for (int i = 0; i < 15; i++) begin
      bus4.mode = tbl[i].mode; bus4.s = tbl[i].s; bus4.v = tbl[i].v; bus4.y_ready = tbl[i].yr;
      cycle();
      chk4($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_valid, tbl[i].e_y, tbl[i].e_sel);
    end

    // Backpressure: first word A5 held through a 4-cycle stall, second word
    // accepted in the cycle y_ready returns.
    bus4.mode = 1'b1; bus4.v = 4'b0010; bus4.d = 32'h4433A511; bus4.y_ready = 1'b1;
    cycle();
    chk4("bp_first", 4'b0010, 1'b1, 8'hA5, 2'd1);
    bus4.d = 32'h44335A11; bus4.y_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk4($sformatf("bp_stall%0d", i), 4'b0000, 1'b1, 8'hA5, 2'd1);
    end
    bus4.y_ready = 1'b1;
    cycle();
    chk4("bp_second", 4'b0010, 1'b1, 8'h5A, 2'd1);
    bus4.v = 4'b0000;
    cycle();
    chk4("bp_drain", 4'b0000, 1'b0, 8'h5A, 2'd1);

    // Mode switch while a channel-2 word is stalled; ptr must stay at 3.
    bus4.d = 32'h44332211; bus4.v = 4'b0100;
    cycle();
    chk4("ms_load", 4'b0100, 1'b1, 8'h33, 2'd2);
    bus4.y_ready = 1'b0; bus4.mode = 1'b0; bus4.s = 2'd0; bus4.v = 4'b1111;
    cycle();
    chk4("ms_stall", 4'b0000, 1'b1, 8'h33, 2'd2);
    bus4.y_ready = 1'b1;
    cycle();
    chk4("ms_fixed", 4'b0001, 1'b1, 8'h11, 2'd0);
    bus4.mode = 1'b1;
    cycle();
    chk4("ms_ptr_kept", 4'b1000, 1'b1, 8'h44, 2'd3);

    // Asynchronous reset between edges clears the held word immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus4.y_valid), 32'd0);
    chk("async_rst_y", 32'(bus4.y), 32'd0);
    chk("async_rst_rdy", 32'(bus4.rdy), 32'd0);
    m4 = '{valid: 0, y: 8'h00, sel: 0, ptr: 0};
    m3 = m4;
    cycle();
    rst_n = 1'b1;

    // N=3: out-of-range select never grants, then s=1 forwards channel 1.
    bus4.v = 4'b0000;
    bus3.mode = 1'b0; bus3.s = 2'd3; bus3.v = 3'b111; bus3.y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("n3_oor_rdy%0d", i), 32'(last_rdy3), 32'd0);
      chk($sformatf("n3_oor_valid%0d", i), 32'(bus3.y_valid), 32'd0);
    end
    bus3.s = 2'd1;
    cycle();
    chk("n3_s1_rdy", 32'(last_rdy3), 32'b010);
    chk("n3_s1_valid", 32'(bus3.y_valid), 32'd1);
    chk("n3_s1_sel", 32'(bus3.y_sel), 32'd1);
    chk("n3_s1_y", 32'(bus3.y), 32'h22);

    // Random traffic on both instances against the reference model.
    for (int i = 0; i < 400; i++) begin
      bus4.mode = 1'($urandom_range(0, 1));
      bus4.s = 2'($urandom_range(0, 3));
      bus4.v = 4'($urandom);
      bus4.d = $urandom;
      bus4.y_ready = ($urandom_range(0, 3) != 0);
      bus3.mode = 1'($urandom_range(0, 1));
      bus3.s = 2'($urandom_range(0, 3));
      bus3.v = 3'($urandom);
      bus3.d = 24'($urandom);
      bus3.y_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
